// File: rtl/cprv_mem_stage.sv
// cprv64g memory-access stage: one in-flight instruction, byte-lane stores, extended loads.
// Optional misalignment trap enabled by defining CPRV_MEM_MISALIGN_TRAP_EN.
module cprv_mem_stage #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_mem_i,
    output logic                  ready_mem_o,
    input  logic [DATA_WIDTH-1:0] alu_out_mem_i,
    input  logic [DATA_WIDTH-1:0] rs2_data_mem_i,
    input  logic [4:0]            rd_addr_mem_i,
    input  logic                  rd_en_mem_i,
    input  logic [6:0]            opcode_mem_i,
    input  logic [2:0]            funct3_mem_i,
    output logic                  dmem_valid_o,
    input  logic                  dmem_ready_i,
    output logic                  dmem_we_o,
    output logic [ADDR_WIDTH-1:0] dmem_addr_o,
    output logic [DATA_WIDTH-1:0] dmem_wdata_o,
    output logic [7:0]            dmem_wstrb_o,
    input  logic                  dmem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] dmem_rdata_i,
    output logic                  valid_wb_o,
    input  logic                  ready_wb_i,
    output logic [DATA_WIDTH-1:0] alu_out_wb_o,
    output logic [DATA_WIDTH-1:0] mem_data_wb_o,
    output logic [4:0]            rd_addr_wb_o,
    output logic                  rd_en_wb_o,
    output logic [6:0]            opcode_wb_o,
    output logic [2:0]            funct3_wb_o
`ifdef CPRV_MEM_MISALIGN_TRAP_EN
    ,
    output logic                  misalign_wb_o
`endif
);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DREQ,
        S_DRESP,
        S_OUT
    } state_t;

    state_t state_q, state_d;

    logic [DATA_WIDTH-1:0] alu_q;
    logic [DATA_WIDTH-1:0] mem_data_q;
    logic [4:0]            rd_addr_q;
    logic                  rd_en_q;
    logic [6:0]            opcode_q;
    logic [2:0]            funct3_q;
    logic [ADDR_WIDTH-1:0] dmem_addr_q;
    logic [DATA_WIDTH-1:0] dmem_wdata_q;
    logic [7:0]            dmem_wstrb_q;
    logic                  dmem_we_q;

    logic                  accept;
    logic                  is_load_in;
    logic                  is_store_in;
    logic                  mem_go;
    logic [2:0]            offset_in;
    logic [7:0]            size_mask;
    logic [7:0]            store_wstrb;
    logic [DATA_WIDTH-1:0] store_wdata;
    logic [DATA_WIDTH-1:0] load_shift;
    logic [DATA_WIDTH-1:0] load_ext;
    logic                  load_sx;

    assign accept      = valid_mem_i & ready_mem_o;
    assign is_load_in  = (opcode_mem_i == OP_LOAD);
    assign is_store_in = (opcode_mem_i == OP_STORE);
    assign offset_in   = alu_out_mem_i[2:0];

`ifdef CPRV_MEM_MISALIGN_TRAP_EN
    logic misaligned_in;
    logic misalign_q;

    always_comb begin
        misaligned_in = 1'b0;
        if (is_load_in || is_store_in) begin
            case (funct3_mem_i[1:0])
                2'b01:   misaligned_in = offset_in[0];
                2'b10:   misaligned_in = |offset_in[1:0];
                2'b11:   misaligned_in = |offset_in;
                default: misaligned_in = 1'b0;
            endcase
        end
    end

    assign mem_go        = (is_load_in | is_store_in) & ~misaligned_in;
    assign misalign_wb_o = misalign_q;
`else
    assign mem_go = is_load_in | is_store_in;
`endif

    always_comb begin
        size_mask = 8'h01;
        case (funct3_mem_i[1:0])
            2'b00: size_mask = 8'h01;
            2'b01: size_mask = 8'h03;
            2'b10: size_mask = 8'h0F;
            2'b11: size_mask = 8'hFF;
            default: size_mask = 8'h01;
        endcase
    end

    // Lanes shifted past byte 7 fall off the top of the 8-bit strobe and 64-bit data.
    assign store_wstrb = size_mask << offset_in;
    assign store_wdata = rs2_data_mem_i << {offset_in, 3'b000};

    assign load_shift = dmem_rdata_i >> {alu_q[2:0], 3'b000};
    assign load_sx    = ~funct3_q[2];

    always_comb begin
        load_ext = load_shift;
        case (funct3_q[1:0])
            2'b00: load_ext = {{56{load_sx & load_shift[7]}},  load_shift[7:0]};
            2'b01: load_ext = {{48{load_sx & load_shift[15]}}, load_shift[15:0]};
            2'b10: load_ext = {{32{load_sx & load_shift[31]}}, load_shift[31:0]};
            2'b11: load_ext = load_shift;
            default: load_ext = load_shift;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = mem_go ? S_DREQ : S_OUT;
            S_DREQ:  if (dmem_ready_i) state_d = dmem_we_q ? S_OUT : S_DRESP;
            S_DRESP: if (dmem_rvalid_i) state_d = S_OUT;
            S_OUT:   if (ready_wb_i) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign ready_mem_o  = (state_q == S_IDLE);
    assign valid_wb_o   = (state_q == S_OUT);
    assign dmem_valid_o = (state_q == S_DREQ);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            alu_q        <= '0;
            mem_data_q   <= '0;
            rd_addr_q    <= '0;
            rd_en_q      <= 1'b0;
            opcode_q     <= '0;
            funct3_q     <= '0;
            dmem_addr_q  <= '0;
            dmem_wdata_q <= '0;
            dmem_wstrb_q <= '0;
            dmem_we_q    <= 1'b0;
`ifdef CPRV_MEM_MISALIGN_TRAP_EN
            misalign_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            if (accept) begin
                alu_q        <= alu_out_mem_i;
                mem_data_q   <= '0;
                rd_addr_q    <= rd_addr_mem_i;
                opcode_q     <= opcode_mem_i;
                funct3_q     <= funct3_mem_i;
                dmem_addr_q  <= {alu_out_mem_i[ADDR_WIDTH-1:3], 3'b000};
                dmem_we_q    <= is_store_in;
                dmem_wdata_q <= is_store_in ? store_wdata : '0;
                dmem_wstrb_q <= is_store_in ? store_wstrb : 8'h00;
`ifdef CPRV_MEM_MISALIGN_TRAP_EN
                rd_en_q      <= rd_en_mem_i & ~misaligned_in;
                misalign_q   <= misaligned_in;
`else
                rd_en_q      <= rd_en_mem_i;
`endif
            end
            if ((state_q == S_DRESP) && dmem_rvalid_i) begin
                mem_data_q <= load_ext;
            end
        end
    end

    assign dmem_addr_o   = dmem_addr_q;
    assign dmem_we_o     = dmem_we_q;
    assign dmem_wdata_o  = dmem_wdata_q;
    assign dmem_wstrb_o  = dmem_wstrb_q;
    assign alu_out_wb_o  = alu_q;
    assign mem_data_wb_o = mem_data_q;
    assign rd_addr_wb_o  = rd_addr_q;
    assign rd_en_wb_o    = rd_en_q;
    assign opcode_wb_o   = opcode_q;
    assign funct3_wb_o   = funct3_q;

endmodule

// File: doc/cprv_mem_stage.md
# cprv_mem_stage

Memory-access stage of the cprv64g pipeline, between the execute stage and the write-back stage. It captures one instruction from execute per handshake and performs loads and stores over a request/response data-memory port. Stores use byte-lane alignment and write strobes; load data is shifted, then sign- or zero-extended. The result goes to write-back over a valid/ready handshake as a single in-flight slot, so at most one instruction is held at a time.

## Interface
Parameters:
- DATA_WIDTH, 64, register/data width (only 64 supported)
- ADDR_WIDTH, 64, data-memory byte address width

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  reset, synchronous and active-high
- valid_mem_i  input  1  execute presents an instruction
- ready_mem_o  output  1  stage can accept; transfer when valid_mem_i & ready_mem_o
- alu_out_mem_i  input  64  ALU result; byte address for LOAD/STORE
- rs2_data_mem_i  input  64  store data
- rd_addr_mem_i  input  5  destination register
- rd_en_mem_i  input  1  destination write enable
- opcode_mem_i  input  7  opcode; LOAD=7'b0000011, STORE=7'b0100011
- funct3_mem_i  input  3  access size/sign
- dmem_valid_o  output  1  memory request valid
- dmem_ready_i  input  1  memory accepts request
- dmem_we_o  output  1  1=store, 0=load
- dmem_addr_o  output  64  {addr[63:3],3'b000}
- dmem_wdata_o  output  64  lane-aligned store data
- dmem_wstrb_o  output  8  byte write strobes (8'h00 on loads)
- dmem_rvalid_i  input  1  load response valid
- dmem_rdata_i  input  64  load response data (aligned doubleword)
- valid_wb_o  output  1  result valid to write-back
- ready_wb_i  input  1  write-back accepts
- alu_out_wb_o, mem_data_wb_o  output  64  ALU result / extended load data
- rd_addr_wb_o  output  5; rd_en_wb_o  output  1; opcode_wb_o  output  7; funct3_wb_o  output  3  forwarded fields

## Operation
- Accepting an instruction registers all *_mem_i fields. Outputs to write-back are driven from these registers.
- State machine:
  - IDLE: ready_mem_o=1. On accept, go to DREQ if the opcode is LOAD or STORE; otherwise go to OUT.
  - DREQ: dmem_valid_o=1, and address, we, wdata and wstrb are held stable. On dmem_ready_i, go to DRESP for a load or OUT for a store.
  - DRESP: wait for dmem_rvalid_i, then capture the extended data into mem_data_wb_o and go to OUT.
  - OUT: valid_wb_o=1, held until ready_wb_i, then return to IDLE.
- ready_mem_o = (state==IDLE) and valid_wb_o = (state==OUT). There is no same-cycle bypass from OUT to accept.
- Byte offset o = addr[2:0].
- Size by funct3:
  - 000 LB, 100 LBU, 000 SB: 1 byte
  - 001 LH, 101 LHU, 001 SH: 2 bytes
  - 010 LW, 110 LWU, 010 SW: 4 bytes
  - 011 LD, 011 SD: 8 bytes
- Store: dmem_wdata_o = rs2 << (8*o); dmem_wstrb_o = size_mask << o, where size_mask is 01/03/0F/FF, truncated to 8 bits.
- Load: s = rdata >> (8*o). Take the low 8, 16, 32 or 64 bits of s. funct3[2]=0 sign-extends; funct3[2]=1 zero-extends.
- For non-memory ops, mem_data_wb_o = 0.
- dmem_rvalid_i outside DRESP is ignored.
- Reset (any state): go to IDLE, valid_wb_o=0, dmem_valid_o=0, all *_wb_o and dmem_* data registers = 0, mem_data_wb_o=0, ready_mem_o=1 in the first cycle after reset. An in-flight response is dropped.

## Timing
- Non-memory op: accept at edge N, valid_wb_o=1 from N+1. Minimum throughput is one instruction per 2 cycles.
- Store: accept at N, dmem_valid_o from N+1. If dmem_ready_i is high at N+1, valid_wb_o=1 from N+2.
- Load: accept at N, request at N+1, accepted at N+1. rvalid in cycle K (K≥N+2) gives valid_wb_o from K+1. Minimum latency is 3 cycles.
- dmem_ready_i stall: request is held unchanged for any number of cycles.
- ready_wb_i stall: OUT is held with outputs stable.

## Configuration
- CPRV_MEM_MISALIGN_TRAP_EN defined:
  - Misalignment is checked at accept: half with o[0]≠0, word with o[1:0]≠0, dword with o≠0.
  - A misaligned access skips DREQ and goes straight to OUT with rd_en_wb_o=0.
  - Adds output misalign_wb_o (1 bit, reset 0), high with valid_wb_o for that instruction. No memory request is issued.
- Undefined: no check is made and misalign_wb_o is absent. Bytes shifted past lane 7 are dropped; the access is issued as computed.

## Test plan
- ADD result 0x1234, ready_wb_i=1 → valid_wb_o one cycle after accept; alu_out_wb_o=0x1234, mem_data_wb_o=0.
- SB at addr 0x1005, rs2=0xAB → dmem_addr_o=0x1000, dmem_wstrb_o=8'h20, dmem_wdata_o[47:40]=0xAB, dmem_we_o=1.
- LB at addr 0x2003, rdata=0x00000000_80000000 → mem_data_wb_o=0xFFFFFFFF_FFFFFF80. LBU at the same address → 0x80.
- LW at 0x3004 with dmem_ready_i low for 3 cycles and rvalid 2 cycles later, rdata[63:32]=0x7FFF0001 → request held stable; mem_data_wb_o=0x7FFF0001; valid_wb_o stays high until ready_wb_i.
- rst asserted in DRESP, then a stale rvalid arrives → IDLE, ready_mem_o=1, no valid_wb_o.
- With CPRV_MEM_MISALIGN_TRAP_EN, LH at 0x4001 → no dmem_valid_o, misalign_wb_o=1, rd_en_wb_o=0.
